// File: rtl/rv0_pkg.sv
// rtl/rv0_pkg.sv - shared AHB-Lite constants and arbiter types for the rv0 core
package rv0_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LSU  = 2'd2
  } arb_owner_e;

  typedef enum logic [1:0] {
    A_IDLE = 2'd0,
    A_IFU  = 2'd1,
    A_LSU  = 2'd2
  } arb_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // A requester only asks for the bus with NONSEQ or SEQ.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/rv0_arb_prio.sv
// rtl/rv0_arb_prio.sv - LSU-first priority pick with saturating IFU starvation counter
module rv0_arb_prio
  import rv0_pkg::*;
#(
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       i_ifu_act,
  input  logic       i_lsu_act,
  input  logic       i_ifu_acc,
  input  logic       i_hold,
  output arb_owner_e o_pick
);

  localparam int unsigned CW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  logic [CW-1:0] r_starve;
  logic          w_forced;

  // A limit of zero never forces the IFU, leaving pure LSU priority.
  assign w_forced = (STARVE_LIM != 0) && (r_starve >= LIM) && i_ifu_act;

  // Fixed priority: LSU unless the IFU has waited long enough.
  always_comb begin
    o_pick = OWN_NONE;
    if (i_lsu_act && !w_forced) begin
      o_pick = OWN_LSU;
    end else if (i_ifu_act) begin
      o_pick = OWN_IFU;
    end
  end

  // Count cycles the IFU loses to the LSU; an accepted IFU transfer clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_starve <= '0;
    end else if (i_ifu_acc) begin
      r_starve <= '0;
    end else if (!i_hold && (o_pick == OWN_LSU) && i_ifu_act && (r_starve < LIM)) begin
      r_starve <= r_starve + CW'(1);
    end
  end

endmodule

// File: rtl/rv0_mem_arb.sv
// rtl/rv0_mem_arb.sv - IFU/LSU AHB-Lite arbiter onto one shared memory port
module rv0_mem_arb
  import rv0_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  // IFU requester port
  input  logic [XLEN-1:0] i_ifu_haddr,
  input  logic [1:0]      i_ifu_htrans,
  input  logic            i_ifu_hwrite,
  input  logic [2:0]      i_ifu_hsize,
  input  logic [XLEN-1:0] i_ifu_hwdata,
  output logic [XLEN-1:0] o_ifu_hrdata,
  output logic            o_ifu_hreadyout,
  output logic            o_ifu_hresp,
  // LSU requester port
  input  logic [XLEN-1:0] i_lsu_haddr,
  input  logic [1:0]      i_lsu_htrans,
  input  logic            i_lsu_hwrite,
  input  logic [2:0]      i_lsu_hsize,
  input  logic [XLEN-1:0] i_lsu_hwdata,
  output logic [XLEN-1:0] o_lsu_hrdata,
  output logic            o_lsu_hreadyout,
  output logic            o_lsu_hresp,
  // shared memory port
  output logic            o_mem_hsel,
  output logic [XLEN-1:0] o_mem_haddr,
  output logic [1:0]      o_mem_htrans,
  output logic            o_mem_hwrite,
  output logic [2:0]      o_mem_hsize,
  output logic [XLEN-1:0] o_mem_hwdata,
  input  logic [XLEN-1:0] i_mem_hrdata,
  input  logic            i_mem_hreadyout,
  input  logic            i_mem_hresp,
  // debug grant {lsu, ifu}
  output logic [1:0]      arb_gnt_o
);

  arb_state_e      r_state;
  arb_state_e      w_state_nxt;
  arb_owner_e      w_gnt;
  arb_owner_e      w_pick;
  arb_owner_e      r_dph;
  arb_owner_e      r_last_own;
  logic [XLEN-1:0] r_haddr;

  logic            w_ifu_act;
  logic            w_lsu_act;
  logic            w_hold;
  logic            w_accept;
  logic            w_ifu_acc;
  logic            w_g_act;
  logic [1:0]      w_g_htrans;
  logic [XLEN-1:0] w_g_haddr;
  logic            w_g_hwrite;
  logic [2:0]      w_g_hsize;

  assign w_ifu_act = htrans_active(i_ifu_htrans);
  assign w_lsu_act = htrans_active(i_lsu_htrans);

  // A stalled memory keeps the address that is already on the bus.
  assign w_hold = !i_mem_hreadyout && (r_state != A_IDLE);

  rv0_arb_prio #(
    .STARVE_LIM (STARVE_LIM)
  ) u_prio (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_ifu_act (w_ifu_act),
    .i_lsu_act (w_lsu_act),
    .i_ifu_acc (w_ifu_acc),
    .i_hold    (w_hold),
    .o_pick    (w_pick)
  );

  // Address-phase state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= A_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant is combinational so the chosen address reaches memory this cycle.
  always_comb begin
    w_gnt       = OWN_NONE;
    w_state_nxt = A_IDLE;
    if (!rst_ni) begin
      w_gnt = OWN_NONE;
    end else if (w_hold) begin
      case (r_state)
        A_IFU:   w_gnt = OWN_IFU;
        A_LSU:   w_gnt = OWN_LSU;
        default: w_gnt = OWN_NONE;
      endcase
    end else begin
      w_gnt = w_pick;
    end
    case (w_gnt)
      OWN_IFU: w_state_nxt = A_IFU;
      OWN_LSU: w_state_nxt = A_LSU;
      default: w_state_nxt = A_IDLE;
    endcase
  end

  // Select the grantee's address-phase signals.
  always_comb begin
    w_g_act    = 1'b0;
    w_g_htrans = HTRANS_IDLE;
    w_g_haddr  = r_haddr;
    w_g_hwrite = 1'b0;
    w_g_hsize  = 3'd0;
    case (w_gnt)
      OWN_IFU: begin
        w_g_act    = w_ifu_act;
        w_g_htrans = i_ifu_htrans;
        w_g_haddr  = i_ifu_haddr;
        w_g_hwrite = i_ifu_hwrite;
        w_g_hsize  = i_ifu_hsize;
      end
      OWN_LSU: begin
        w_g_act    = w_lsu_act;
        w_g_htrans = i_lsu_htrans;
        w_g_haddr  = i_lsu_haddr;
        w_g_hwrite = i_lsu_hwrite;
        w_g_hsize  = i_lsu_hsize;
      end
      default: ;
    endcase
  end

  assign w_accept  = w_g_act && i_mem_hreadyout;
  assign w_ifu_acc = w_accept && (w_gnt == OWN_IFU);

  // Track the data-phase owner, the owner of the last accepted transfer and the last address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_dph      <= OWN_NONE;
      r_last_own <= OWN_NONE;
      r_haddr    <= '0;
    end else begin
      if (i_mem_hreadyout) begin
        r_dph <= w_accept ? w_gnt : OWN_NONE;
      end
      if (w_accept) begin
        r_last_own <= w_gnt;
      end
      if (w_gnt != OWN_NONE) begin
        r_haddr <= w_g_haddr;
      end
    end
  end

  // A burst continuation must restart as NONSEQ after the other requester used the bus.
  always_comb begin
    o_mem_htrans = w_g_htrans;
    if (w_gnt == OWN_NONE) begin
      o_mem_htrans = HTRANS_IDLE;
    end else if ((w_g_htrans == HTRANS_SEQ) && (r_last_own != w_gnt)) begin
      o_mem_htrans = HTRANS_NONSEQ;
    end
  end

  assign o_mem_hsel   = 1'b1;
  assign o_mem_haddr  = w_g_haddr;
  assign o_mem_hwrite = w_g_hwrite;
  assign o_mem_hsize  = w_g_hsize;
  assign arb_gnt_o    = {w_gnt == OWN_LSU, w_gnt == OWN_IFU};

  // Write data follows whoever owns the data phase.
  always_comb begin
    o_mem_hwdata = '0;
    case (r_dph)
      OWN_IFU: o_mem_hwdata = i_ifu_hwdata;
      OWN_LSU: o_mem_hwdata = i_lsu_hwdata;
      default: ;
    endcase
  end

  assign o_ifu_hrdata = i_mem_hrdata;
  assign o_lsu_hrdata = i_mem_hrdata;

  // A requester waits while memory stalls or while its pending address is denied.
  always_comb begin
    o_ifu_hreadyout = 1'b1;
    o_lsu_hreadyout = 1'b1;
    if ((r_dph == OWN_IFU) || w_ifu_act) begin
      o_ifu_hreadyout = i_mem_hreadyout && (!w_ifu_act || (w_gnt == OWN_IFU));
    end
    if ((r_dph == OWN_LSU) || w_lsu_act) begin
      o_lsu_hreadyout = i_mem_hreadyout && (!w_lsu_act || (w_gnt == OWN_LSU));
    end
    if (!rst_ni) begin
      o_ifu_hreadyout = 1'b1;
      o_lsu_hreadyout = 1'b1;
    end
  end

  assign o_ifu_hresp = (r_dph == OWN_IFU) ? i_mem_hresp : HRESP_OKAY;
  assign o_lsu_hresp = (r_dph == OWN_LSU) ? i_mem_hresp : HRESP_OKAY;

endmodule

// File: tb/tb_rv0_mem_arb.sv
// tb/tb_rv0_mem_arb.sv - randomized bench for rv0_mem_arb against a behavioural model
module tb_rv0_mem_arb;

  localparam int LIM = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  always #5 clk_i = ~clk_i;

  logic [31:0] q_addr  [1:2];
  logic [1:0]  q_htr   [1:2];
  logic        q_wr    [1:2];
  logic [2:0]  q_size  [1:2];
  logic [31:0] q_wdata [1:2];

  logic [31:0] ifu_hrdata, lsu_hrdata;
  logic        ifu_rdy, lsu_rdy, ifu_resp, lsu_resp;
  logic        mem_hsel, mem_hwrite;
  logic [31:0] mem_haddr, mem_hwdata;
  logic [1:0]  mem_htrans, gnt;
  logic [2:0]  mem_hsize;
  logic [31:0] mem_hrdata;
  logic        mem_rdy, mem_resp;

  rv0_mem_arb #(.XLEN(32), .STARVE_LIM(LIM)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .i_ifu_haddr     (q_addr[1]),
    .i_ifu_htrans    (q_htr[1]),
    .i_ifu_hwrite    (q_wr[1]),
    .i_ifu_hsize     (q_size[1]),
    .i_ifu_hwdata    (q_wdata[1]),
    .o_ifu_hrdata    (ifu_hrdata),
    .o_ifu_hreadyout (ifu_rdy),
    .o_ifu_hresp     (ifu_resp),
    .i_lsu_haddr     (q_addr[2]),
    .i_lsu_htrans    (q_htr[2]),
    .i_lsu_hwrite    (q_wr[2]),
    .i_lsu_hsize     (q_size[2]),
    .i_lsu_hwdata    (q_wdata[2]),
    .o_lsu_hrdata    (lsu_hrdata),
    .o_lsu_hreadyout (lsu_rdy),
    .o_lsu_hresp     (lsu_resp),
    .o_mem_hsel      (mem_hsel),
    .o_mem_haddr     (mem_haddr),
    .o_mem_htrans    (mem_htrans),
    .o_mem_hwrite    (mem_hwrite),
    .o_mem_hsize     (mem_hsize),
    .o_mem_hwdata    (mem_hwdata),
    .i_mem_hrdata    (mem_hrdata),
    .i_mem_hreadyout (mem_rdy),
    .i_mem_hresp     (mem_resp),
    .arb_gnt_o       (gnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // memory slave state
  int          m_busy, m_wait, m_err;
  logic [31:0] m_addr;
  // arbiter model state: owners are 0 none, 1 ifu, 2 lsu
  int          s_pg, s_dph, s_starve, s_lacc;
  logic [31:0] s_laddr;
  // values seen at the last sample point
  int          sp_gnt;
  bit          sp_hold, sp_mr;
  bit          sp_act [1:2];
  bit          sp_rdy [1:2];
  logic [1:0]  sp_mhtr;
  logic [31:0] sp_maddr, sp_gaddr;
  // stimulus knobs
  int          p_act [1:2];
  int          wmax, epct;
  bit          force_seq;

  function automatic logic [31:0] rdfn(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1234_5678;
  endfunction

  task automatic model_reset();
    s_pg = 0; s_dph = 0; s_starve = 0; s_lacc = 0; s_laddr = '0;
    m_busy = 0; m_wait = 0; m_err = 0; m_addr = '0;
    sp_gnt = 0; sp_hold = 0; sp_mr = 1; sp_mhtr = 2'b00; sp_maddr = '0; sp_gaddr = '0;
    for (int x = 1; x <= 2; x++) begin
      sp_act[x] = 0; sp_rdy[x] = 1;
      q_htr[x] = 2'b00; q_addr[x] = '0; q_wr[x] = 0; q_size[x] = 3'd2; q_wdata[x] = '0;
    end
  endtask

  task automatic drive_mem();
    mem_hrdata = '0; mem_rdy = 1'b1; mem_resp = 1'b0;
    if (m_busy != 0) begin
      if (m_wait > 0) mem_rdy = 1'b0;
      else if (m_err == 1) begin mem_rdy = 1'b0; mem_resp = 1'b1; end
      else if (m_err == 2) mem_resp = 1'b1;
      else mem_hrdata = rdfn(m_addr);
    end
  endtask

  // Advance model, memory and requesters using what was seen before the edge.
  task automatic edge_update();
    if (sp_gnt != 0) s_laddr = sp_gaddr;
    if (sp_mr) begin
      if (sp_gnt != 0 && sp_act[sp_gnt]) begin s_dph = sp_gnt; s_lacc = sp_gnt; end
      else s_dph = 0;
    end
    if (sp_gnt == 1 && sp_act[1] && sp_mr) s_starve = 0;
    else if (!sp_hold && sp_gnt == 2 && sp_act[1] && s_starve < LIM) s_starve++;
    s_pg = sp_gnt;

    if (m_busy != 0) begin
      if (m_wait > 0) m_wait--;
      else if (m_err == 1) m_err = 2;
      else m_busy = 0;
    end
    if (sp_mr && sp_mhtr[1]) begin
      m_busy = 1; m_addr = sp_maddr;
      m_wait = $urandom_range(wmax, 0);
      m_err  = ($urandom_range(99, 0) < epct) ? 1 : 0;
    end

    for (int x = 1; x <= 2; x++) begin
      if (sp_rdy[x]) begin
        q_wdata[x] = (sp_act[x] && q_wr[x]) ? (q_addr[x] ^ 32'h5A5A_0000 ^ x) : 32'h0;
        if (force_seq) begin
          q_htr[x]  = (x == 1) ? 2'b11 : 2'b00;
          q_addr[x] = 32'h44; q_wr[x] = 1'b0;
        end else if ($urandom_range(99, 0) < p_act[x]) begin
          if (q_htr[x][1] && $urandom_range(1, 0) == 1) begin
            q_htr[x] = 2'b11; q_addr[x] = q_addr[x] + 32'd4;
          end else begin
            q_htr[x] = 2'b10; q_addr[x] = $urandom_range(255, 0) << 2;
          end
          q_wr[x] = (x == 2) ? 1'($urandom_range(1, 0)) : 1'b0;
          q_size[x] = 3'd2;
        end else begin
          q_htr[x] = 2'b00;
        end
      end
    end
    force_seq = 0;
  endtask

  // Compare every output with the rules applied to the current inputs.
  task automatic check_cycle();
    bit ia, la, mr, hold, act;
    int g;
    logic [1:0]  e_htr, t;
    logic [31:0] e_addr, e_wd;
    logic [1:0]  e_gnt;
    bit          e_rdy [1:2];
    bit          e_rsp [1:2];
    ia = q_htr[1][1]; la = q_htr[2][1]; mr = mem_rdy;
    hold = !mr && s_pg != 0;
    if (hold) g = s_pg;
    else if (la && !(LIM != 0 && s_starve >= LIM && ia)) g = 2;
    else if (ia) g = 1;
    else g = 0;
    if (g == 0) begin
      e_htr = 2'b00; e_addr = s_laddr;
    end else begin
      t = q_htr[g];
      e_htr = (t == 2'b11 && s_lacc != g) ? 2'b10 : t;
      e_addr = q_addr[g];
    end
    e_gnt = (g == 2) ? 2'b10 : (g == 1) ? 2'b01 : 2'b00;
    e_wd = (s_dph == 0) ? 32'h0 : q_wdata[s_dph];
    for (int x = 1; x <= 2; x++) begin
      act = q_htr[x][1];
      e_rdy[x] = (s_dph == x || act) ? (mr && (!act || g == x)) : 1'b1;
      e_rsp[x] = (s_dph == x) ? mem_resp : 1'b0;
    end
    check("htrans", mem_htrans, e_htr);
    check("haddr", mem_haddr, e_addr);
    check("gnt", gnt, e_gnt);
    check("hwrite", mem_hwrite, (g == 0) ? 1'b0 : q_wr[g]);
    check("hwdata", mem_hwdata, e_wd);
    check("rdy_ifu", ifu_rdy, e_rdy[1]);
    check("rdy_lsu", lsu_rdy, e_rdy[2]);
    check("resp_ifu", ifu_resp, e_rsp[1]);
    check("resp_lsu", lsu_resp, e_rsp[2]);
    check("rdata_ifu", ifu_hrdata, mem_hrdata);
    check("rdata_lsu", lsu_hrdata, mem_hrdata);
    sp_gnt = g; sp_hold = hold; sp_mr = mr;
    sp_mhtr = e_htr; sp_maddr = e_addr; sp_gaddr = (g == 0) ? s_laddr : q_addr[g];
    for (int x = 1; x <= 2; x++) begin
      sp_act[x] = q_htr[x][1]; sp_rdy[x] = e_rdy[x];
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1; edge_update(); drive_mem();
      @(negedge clk_i); check_cycle();
    end
  endtask

  task automatic check_reset_vals();
    check("rst_htrans", mem_htrans, 2'b00);
    check("rst_haddr", mem_haddr, 32'h0);
    check("rst_gnt", gnt, 2'b00);
    check("rst_rdy_ifu", ifu_rdy, 1'b1);
    check("rst_rdy_lsu", lsu_rdy, 1'b1);
    check("rst_resp_ifu", ifu_resp, 1'b0);
    check("rst_resp_lsu", lsu_resp, 1'b0);
    check("rst_hsel", mem_hsel, 1'b1);
  endtask

  task automatic set_knobs(input int pi, input int pl, input int w, input int e);
    p_act[1] = pi; p_act[2] = pl; wmax = w; epct = e;
  endtask

  // Reset during an IFU wait state, then make the first transfer a SEQ.
  task automatic reset_mid_burst();
    bit found;
    found = 0;
    set_knobs(100, 0, 2, 0);
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk_i); #1; edge_update(); drive_mem();
      if (!mem_rdy && q_htr[1][1]) found = 1;
      else begin @(negedge clk_i); check_cycle(); end
    end
    check("rst_wait_found", 64'(found), 64'd1);
    #2 rst_ni = 1'b0;
    #1 check_reset_vals();
    model_reset(); drive_mem();
    @(posedge clk_i); #1 check_reset_vals();
    @(negedge clk_i); rst_ni = 1'b1;
    force_seq = 1;
    set_knobs(0, 0, 0, 0);
    run(3);
  endtask

  initial begin
    rst_ni = 1'b0;
    force_seq = 0;
    set_knobs(0, 0, 0, 0);
    model_reset(); drive_mem();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); check_reset_vals();
    rst_ni = 1'b1;

    set_knobs(100, 0, 0, 0);   run(30);
    set_knobs(100, 100, 0, 0); run(60);
    set_knobs(100, 100, 2, 0); run(60);
    set_knobs(60, 60, 2, 15);  run(300);
    set_knobs(80, 80, 1, 5);   run(200);
    reset_mid_burst();
    set_knobs(70, 70, 2, 10);  run(150);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
